teak__fixed_x2e__x24_method__int26__6__div: RTL and testbench

Sequential 26d6 ÷ 26d6 signed fixed-point divider with a 32-bit 26d6 result, the inverse operation of the Int26_6 multiplier. It sits in the same method-call slot and uses the same operand/result handshakes. It computes one restoring-division quotient bit per cycle on magnitudes, then applies sign, divide-by-zero and overflow handling. Throughput is one division per 40 cycles.

---
 rtl/teak__fixed_x2e__x24_method__int26__6__div.sv | 100 ++++++++++
 tb/tb_teak__fixed_x2e__x24_method__int26__6__div.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/teak__fixed_x2e__x24_method__int26__6__div.sv
// teak__fixed_x2e__x24_method__int26__6__div: sequential Q26.6 signed divider, one quotient bit per cycle.
// Optional macro FIXED_DIV_SATURATE_EN clamps out-of-range quotients instead of wrapping them.
module teak__fixed_x2e__x24_method__int26__6__div (
    input  logic        clk,
    input  logic        srst,
    input  logic        goValid,
    output logic        goStop,
    output logic        doneValid,
    input  logic        doneStop,
    input  logic        operandsReady,
    input  logic [63:0] operandsData,
    output logic        operandsStop,
    output logic        resultReady,
    output logic [31:0] resultData,
    input  logic        resultStop
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]  state;
    logic        operandsValid_q;
    logic [31:0] aQ, bQ, bMag;
    logic [32:0] rem;
    logic [37:0] quot;
    logic [5:0]  count;
    logic        neg, aneg, dz;
    logic        resultBufValid_q;
    logic [31:0] resultBufData_q;
    logic [32:0] remShift, remDiff;
    logic        remGe;
    logic [31:0] aMag, bAbs, wrapped, result;
    logic        bufWrite;

    assign goStop = doneStop;
    assign doneValid = goValid;
    assign operandsStop = operandsValid_q & (state != IDLE);
    assign resultReady = resultBufValid_q;
    assign resultData = resultBufData_q;

    // Magnitudes are unsigned 32-bit, so the most negative operand becomes 2^31.
    // The quotient register starts out holding the dividend and is shifted out as quotient bits shift in.
    always_comb begin
        aMag = aQ[31] ? -aQ : aQ;
        bAbs = bQ[31] ? -bQ : bQ;
        remShift = {rem[31:0], quot[37]};
        remDiff = remShift - {1'b0, bMag};
        remGe = remShift >= {1'b0, bMag};
        wrapped = neg ? -quot[31:0] : quot[31:0];
`ifdef FIXED_DIV_SATURATE_EN
        result = dz ? (aneg ? 32'h8000_0000 : 32'h7FFF_FFFF) :
                 (!neg && quot > 38'h00_7FFF_FFFF) ? 32'h7FFF_FFFF :
                 (neg && quot > 38'h00_8000_0000) ? 32'h8000_0000 : wrapped;
`else
        result = dz ? (aneg ? 32'h8000_0000 : 32'h7FFF_FFFF) : wrapped;
`endif
        bufWrite = (state == FINISH) && !resultBufValid_q;
    end

    // Input register refills whenever it is not holding operands back.
    always_ff @(posedge clk) begin
        if (srst) operandsValid_q <= 1'b0;
        else if (!operandsStop) operandsValid_q <= operandsReady;
        if (!operandsStop) {bQ, aQ} <= operandsData;
    end

    // Division sequencer: load, 38 restoring iterations, then hand off to the output buffer.
    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else if (state == IDLE) state <= operandsValid_q ? DIV : IDLE;
        else if (state == DIV) state <= (count == 6'd0) ? FINISH : DIV;
        else if (state == FINISH) state <= resultBufValid_q ? FINISH : IDLE;
        else state <= IDLE;
    end

    // Datapath is deliberately left unreset; results only escape through the reset-guarded buffer.
    always_ff @(posedge clk) begin
        if (state == IDLE && operandsValid_q) begin
            quot <= {aMag, 6'b0};
            bMag <= bAbs;
            rem <= 33'd0;
            count <= 6'd37;
            neg <= aQ[31] ^ bQ[31];
            aneg <= aQ[31];
            dz <= (bQ == 32'd0);
        end else if (state == DIV) begin
            rem <= remGe ? remDiff : remShift;
            quot <= {quot[36:0], remGe};
            count <= count - 6'd1;
        end
    end

    // Single-entry output buffer; a stalled FINISH writes on the edge after it drains.
    always_ff @(posedge clk) begin
        if (srst) resultBufValid_q <= 1'b0;
        else if (bufWrite) resultBufValid_q <= 1'b1;
        else if (resultBufValid_q && !resultStop) resultBufValid_q <= 1'b0;
        if (bufWrite) resultBufData_q <= result;
    end
endmodule

// File: tb/tb_teak__fixed_x2e__x24_method__int26__6__div.sv
// tb_teak__fixed_x2e__x24_method__int26__6__div: scoreboard bench for the Q26.6 divider.
module tb_teak__fixed_x2e__x24_method__int26__6__div;
    logic        clk = 0;
    logic        srst = 1;
    logic        goValid = 0;
    logic        goStop;
    logic        doneValid;
    logic        doneStop = 0;
    logic        operandsReady = 0;
    logic [63:0] operandsData = '0;
    logic        operandsStop;
    logic        resultReady;
    logic [31:0] resultData;
    logic        resultStop = 0;

    int passed = 0;
    int total = 0;
    logic sawStop = 0;
    logic [31:0] expQ[$];

`ifdef FIXED_DIV_SATURATE_EN
    localparam logic [31:0] OVF_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_EXP = 32'hFFFF_FFC0;
`endif

    teak__fixed_x2e__x24_method__int26__6__div dut (
        .clk(clk), .srst(srst), .goValid(goValid), .goStop(goStop),
        .doneValid(doneValid), .doneStop(doneStop),
        .operandsReady(operandsReady), .operandsData(operandsData), .operandsStop(operandsStop),
        .resultReady(resultReady), .resultData(resultData), .resultStop(resultStop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every result transfer pops the scoreboard in order.
    always @(negedge clk) begin
        if (!srst && resultReady && !resultStop) begin
            if (expQ.size() == 0) begin
                total++;
                $display("FAIL unexpected_result: got %h expected none at %0t", resultData, $time);
            end else chk("result", resultData, expQ.pop_front());
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n = 0;
        logic acc = 0;
        operandsReady = 1;
        operandsData = {b, a};
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = !operandsStop;
            if (!acc) sawStop = 1;
            @(posedge clk);
            #1;
            n++;
        end
        operandsReady = 0;
        if (acc) expQ.push_back(exp);
        else begin
            total++;
            $display("FAIL send_timeout: got stalled expected accept a=%h b=%h", a, b);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((expQ.size() != 0 || resultReady) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", expQ.size(), 0);
    endtask

    task automatic latency(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        send(a, b, exp);
        repeat (39) @(posedge clk);
        #1;
        chk("ready_before_40", {31'd0, resultReady}, 0);
        @(posedge clk);
        #1;
        chk("ready_at_40", {31'd0, resultReady}, 1);
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        srst = 0;
        chk("reset_ready", {31'd0, resultReady}, 0);
        chk("reset_opstop", {31'd0, operandsStop}, 0);
        goValid = 1;
        doneStop = 1;
        #1;
        chk("done_valid_hi", {31'd0, doneValid}, 1);
        chk("go_stop_hi", {31'd0, goStop}, 1);
        goValid = 0;
        doneStop = 0;
        #1;
        chk("done_valid_lo", {31'd0, doneValid}, 0);
        chk("go_stop_lo", {31'd0, goStop}, 0);
        latency(32'h0000_0180, 32'h0000_0080, 32'h0000_00C0);
        send(32'hFFFF_FFC0, 32'h0000_00C0, 32'hFFFF_FFEB);
        send(32'h0000_0100, 32'h0000_0000, 32'h7FFF_FFFF);
        send(32'hFFFF_FF00, 32'h0000_0000, 32'h8000_0000);
        send(32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF);
        send(32'h7FFF_FFFF, 32'h0000_0001, OVF_EXP);
        send(32'h8000_0000, 32'h0000_0040, 32'h8000_0000);
        send(32'h0000_0000, 32'hFFFF_FFC0, 32'h0000_0000);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0040);
        send(32'h0000_0060, 32'hFFFF_FFE0, 32'hFFFF_FF40);
        drain();
        resultStop = 1;
        sawStop = 0;
        send(32'h0000_0180, 32'h0000_0080, 32'h0000_00C0);
        send(32'hFFFF_FFC0, 32'h0000_00C0, 32'hFFFF_FFEB);
        send(32'h0000_0060, 32'hFFFF_FFE0, 32'hFFFF_FF40);
        chk("opstop_busy", {31'd0, sawStop}, 1);
        repeat (50) @(posedge clk);
        #1;
        chk("held_count", expQ.size(), 3);
        chk("held_ready", {31'd0, resultReady}, 1);
        chk("held_data", resultData, 32'h0000_00C0);
        resultStop = 0;
        drain();
        send(32'h0000_0180, 32'h0000_0080, 32'h0000_00C0);
        repeat (20) @(posedge clk);
        #1;
        srst = 1;
        @(posedge clk);
        #1;
        srst = 0;
        expQ.delete();
        chk("rst_mid_ready", {31'd0, resultReady}, 0);
        chk("rst_mid_opstop", {31'd0, operandsStop}, 0);
        repeat (60) @(posedge clk);
        #1;
        latency(32'hFFFF_FFC0, 32'h0000_00C0, 32'hFFFF_FFEB);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
